// File: rtl/arb_pkg.sv
// Shared constants and types for the 16-requester round-robin arbiter.
//   NUM_REQ      : number of requesters (fixed by the 4-to-16 grant decoder)
//   IDX_W        : width of grant index and round-robin pointer
//   MAX_HOLD_DEF : default cap on consecutive grant cycles (timeout build only)
//   state_e      : arbiter state {IDLE, GRANT}
package arb_pkg;

    localparam int unsigned NUM_REQ      = 16;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between requesters and the arbiter.
//   en        : arbitration enable (0 blocks new grants only)
//   req       : request vector, held high by each requester until done
//   gnt       : one-hot grant, zero when no grant is held
//   gnt_idx   : index of the current owner, 0 when idle
//   gnt_valid : high while a grant is held
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_16_if;
    import arb_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );

endinterface

// File: rtl/dec_4to16.sv
// 4-to-16 one-hot decoder with enable.
//   en          : output is all zero when low
//   in3..in0    : binary select, in3 is the MSB
//   y[15:0]     : one-hot decode of {in3,in2,in1,in0}
module dec_4to16 (
    input  logic        en,
    input  logic        in3,
    input  logic        in2,
    input  logic        in1,
    input  logic        in0,
    output logic [15:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[{in3, in2, in1, in0}] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_pick16.sv
// Rotating-priority finder: returns the first set bit of (req & ~mask),
// scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1.
//   req   : request vector
//   ptr   : highest-priority position
//   mask  : bits excluded from this pick
//   idx   : winning index (0 when nothing found)
//   found : at least one eligible request
module rr_pick16
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   pos;

    assign eligible = req & ~mask;

    // Scan from the farthest distance back to ptr so the nearest hit is
    // the last assignment and therefore wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + IDX_W'(k);
            if (eligible[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter for one shared resource.
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rr_arbiter_16_if.slave (en, req in; gnt, gnt_idx, gnt_valid out)
// Optional build macro RR_ARB_TIMEOUT_EN adds the MAX_HOLD parameter and a
// hold counter that revokes a grant after MAX_HOLD consecutive cycles.
module rr_arbiter_16
    import arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_16_if.slave bus
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               owner_req;
    logic               revoke;

    assign owner_req = bus.req[idx_q];

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;

    assign revoke    = (state_q == GRANT) && owner_req && (hold_q == 8'(MAX_HOLD - 1));
    // A revoked owner still has its request up; keep it out of this pick.
    assign pick_mask = revoke ? (NUM_REQ'(1) << idx_q) : '0;
`else
    assign revoke    = 1'b0;
    assign pick_mask = '0;
`endif

    // On a release/revocation the scan starts just past the outgoing owner,
    // i.e. from the pointer value being registered at this same edge.
    assign pick_ptr = (state_q == GRANT) ? idx_q + IDX_W'(1) : ptr_q;

    rr_pick16 u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.en && pick_found) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req || revoke) begin
                    ptr_d = idx_q + IDX_W'(1);
                    if (bus.en && pick_found) begin
                        idx_d   = pick_idx;
                        valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_d  = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;

    dec_4to16 u_dec (
        .en  (valid_q),
        .in3 (idx_q[3]),
        .in2 (idx_q[2]),
        .in1 (idx_q[1]),
        .in0 (idx_q[0]),
        .y   (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16. Inputs change 1 time unit after a rising
// edge; outputs are sampled there as well, away from the edge.
module tb_rr_arbiter_16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rr_arbiter_16_if bus ();

    rr_arbiter_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] idx);
        logic [15:0] oh;
        oh = 16'h0001 << idx;
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(oh));
        check({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
        check({tag, ".valid"}, 32'(bus.gnt_valid), 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
        check({tag, ".idx"}, 32'(bus.gnt_idx), 32'd0);
        check({tag, ".valid"}, 32'(bus.gnt_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = 16'h0000;
        tick();
        tick();
        expect_idle("reset_init");

        // Reset mid-grant, after ptr has moved to 1.
        rst_n   = 1'b1;
        bus.en  = 1'b1;
        bus.req = 16'hFFFF;
        tick();
        expect_grant("rst_first", 4'd0);
        bus.req = 16'hFFFE;
        tick();
        expect_grant("rst_handoff", 4'd1);
        rst_n = 1'b0;
        #1;
        expect_idle("rst_async");
        bus.req = 16'hFFFF;
        tick();
        rst_n = 1'b1;
        tick();
        expect_grant("rst_after", 4'd0);

        // Rotation between 0 and 15, no idle cycle on handoff.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h8001;
        tick();
        expect_grant("rot0", 4'd0);
        bus.req = 16'h8000;
        tick();
        expect_grant("rot1", 4'd15);
        bus.req = 16'h8001;
        tick();
        bus.req = 16'h0001;
        tick();
        expect_grant("rot2", 4'd0);
        bus.req = 16'h8001;
        tick();
        bus.req = 16'h8000;
        tick();
        expect_grant("rot3", 4'd15);

        // Wrap: ptr=15 after owner 14 releases; 0 beats 14.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h4000;
        tick();
        expect_grant("wrap_14", 4'd14);
        bus.req = 16'h0000;
        tick();
        expect_idle("wrap_rel");
        bus.req = 16'h4001;
        tick();
        expect_grant("wrap_0", 4'd0);

        // Enable gating, then en=0 during a grant.
        do_reset();
        bus.en  = 1'b0;
        bus.req = 16'h0010;
        tick();
        tick();
        expect_idle("en_off");
        bus.en = 1'b1;
        #1;
        expect_idle("en_latency");
        tick();
        expect_grant("en_on", 4'd4);
        bus.en  = 1'b0;
        bus.req = 16'h0030;
        tick();
        expect_grant("en_off_hold", 4'd4);
        bus.req = 16'h0020;
        tick();
        expect_idle("en_off_rel");

        // Single requester drop/raise: one idle cycle between grants.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h0004;
        tick();
        expect_grant("single_a", 4'd2);
        bus.req = 16'h0000;
        tick();
        expect_idle("single_gap");
        bus.req = 16'h0004;
        tick();
        expect_grant("single_b", 4'd2);

`ifdef RR_ARB_TIMEOUT_EN
        // Timeout with MAX_HOLD=8: 1 for 8 cycles, 2 for 8, then 1.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h0006;
        tick();
        expect_grant("to_c0", 4'd1);
        for (int c = 1; c <= 16; c++) begin
            logic [3:0] e;
            e = (c < 8) ? 4'd1 : (c < 16) ? 4'd2 : 4'd1;
            tick();
            expect_grant($sformatf("to_c%0d", c), e);
        end
`else
        // Hold: owner 3 keeps the grant indefinitely.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h0008;
        tick();
        expect_grant("hold_start", 4'd3);
        bus.req = 16'hFFFF;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("hold_c%0d", c), 32'(bus.gnt), 32'h0008);
        end
        bus.req = 16'hFFF7;
        tick();
        expect_grant("hold_rel", 4'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- 16-requester round-robin arbiter that grants one shared resource at a time.
- The winner is held as a 4-bit index.
- The one-hot grant vector is produced by the team's existing dec_4to16 decoder, with the decoder enable driven by grant-valid.
- Sits in front of any shared slot (bus, memory port, output lane) whose select is decoded 4-to-16.

Parameters:
- NUM_REQ, 16, number of requesters; fixed to 16 to match the 4-to-16 grant decoder.
- IDX_W, 4, width of the grant index and of the round-robin pointer.
- MAX_HOLD, 8, maximum consecutive grant cycles per owner; used only with RR_ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; 0 blocks new grants only.
- req  input  16  request vector; req[i] is held high by requester i until it is done.
- gnt  output  16  one-hot grant; all zero when gnt_valid=0.
- gnt_idx  output  4  index of the current owner; 0 when idle.
- gnt_valid  output  1  high while a grant is held.

Behaviour:
- Reset (async assert, sync deassert at the next clk edge after rst_n rises):
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0.
  - Reset mid-grant drops the grant immediately, with no handshake.
- States: IDLE, GRANT. All outputs are registered; gnt is a pure decode of registered gnt_idx/gnt_valid.
- Pick function: the first i with req[i]=1, scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
- IDLE:
  - If en=1 and req!=0: next edge go to GRANT, gnt_idx=pick, gnt_valid=1.
  - Latency is 1 cycle from req sampled high to gnt high.
  - Otherwise stay in IDLE.
- GRANT, req[gnt_idx]=1: hold the grant. Changes on other req bits are ignored.
- GRANT, req[gnt_idx]=0 (release):
  - ptr <= gnt_idx+1, wrapping 15 to 0.
  - If en=1 and other requests are pending, the new grant is registered at the same edge, scanning from the new ptr. Back-to-back handoff has no idle cycle.
  - Otherwise go to IDLE with gnt_valid=0.
- en=0 during GRANT: the current owner keeps the grant until release; no successor is granted; go to IDLE.
- Simultaneous requests: the lowest rotated distance from ptr wins.
- The owner re-requesting on the release cycle is ineligible that cycle, because its bit is low. It competes normally afterwards, ranked last since ptr has moved past it.
- Single requester repeatedly dropping and raising req: granted each time, with one IDLE cycle between grants.
- ptr advances only on release or revocation, never in IDLE.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (8 bits) clears on each new grant and increments every GRANT cycle.
  - When hold_cnt reaches MAX_HOLD-1 with req[gnt_idx] still high, the grant is revoked at that edge.
  - Revocation behaves exactly like a release (ptr <= gnt_idx+1, handoff or IDLE), but the revoked index is masked out of this pick.
  - Maximum continuous ownership is MAX_HOLD cycles. A sole requester is regranted after one IDLE cycle.
- Undefined: no counter logic exists; a grant is held indefinitely until release.

Decomposition:
- Shared package arb_pkg:
  - NUM_REQ and IDX_W constants.
  - State type {IDLE, GRANT}.
  - Default MAX_HOLD.
- Sub-module rr_pick16: combinational rotating-priority finder.
  - Inputs: req[15:0], ptr[3:0], mask[15:0].
  - Outputs: idx[3:0], found.
- The one-hot gnt comes from one instance of the existing dec_4to16 (en=gnt_valid, in3..in0=gnt_idx). No separate one-hot register.

Test Plan:
- Reset: assert rst_n=0 mid-grant with req=16'hFFFF -> gnt=0, gnt_idx=0, gnt_valid=0 immediately; after release, first grant is idx 0.
- Rotation: req=16'h8001 held; each owner drops for one cycle then re-raises -> grant order 0, 15, 0, 15; handoffs have no idle cycle.
- Wrap: ptr=15 via grant to 14 then release, req=16'h4001 -> idx 0 wins (not 14).
- Enable gating: en=0 with req=16'h0010 -> gnt stays 0; en=1 -> gnt=16'h0010 one cycle later, gnt_idx=4.
- Hold: owner 3 holds for 20 cycles while req=16'hFFFF (feature off) -> gnt=16'h0008 throughout; release -> idx 4 next edge.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=8): req=16'h0006 held -> idx 1 for 8 cycles, idx 2 for 8 cycles, then idx 1 again.
